// File: rtl/pe_pkg.sv
// Shared types and helpers for the vector systolic PE: saturating add, lane slicing, width rule.
// Pure package, no state.
package pe_pkg;

  localparam int ACC_MAX_W = 64;

  typedef struct packed {
    logic                        ovf;
    logic signed [ACC_MAX_W-1:0] val;
  } sat_res_t;

  // s is the (w+1)-bit sum, sign-extended into ACC_MAX_W+1 bits; result valid in the low w bits.
  function automatic sat_res_t sat_add(input logic signed [ACC_MAX_W:0] s, input int w,
                                       input logic sat_en);
    logic signed [ACC_MAX_W:0] hi, lo, wr;
    sat_res_t res;
    hi      = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo      = -(65'sd1 <<< (w - 1));
    wr      = (s <<< (ACC_MAX_W + 1 - w)) >>> (ACC_MAX_W + 1 - w);
    res.ovf = (s > hi) || (s < lo);
    if (!res.ovf)    res.val = s[ACC_MAX_W-1:0];
    else if (sat_en) res.val = (s > hi) ? hi[ACC_MAX_W-1:0] : lo[ACC_MAX_W-1:0];
    else             res.val = wr[ACC_MAX_W-1:0];
    return res;
  endfunction

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  function automatic bit width_ok(input int d_w, input int d_w_acc, input int lanes);
    return (d_w_acc >= 2 * d_w + $clog2(lanes)) && (d_w_acc <= ACC_MAX_W) && (lanes >= 1);
  endfunction

endpackage

// File: rtl/pe_dot.sv
// Lane multipliers and adder tree producing one dot-product slice; optional output register.
// Latency 0 or 1 (PIPE_MUL); en=0 holds the pipeline register.
module pe_dot
  import pe_pkg::*;
#(
  parameter int D_W      = 8,
  parameter int D_W_ACC  = 32,
  parameter int LANES    = 4,
  parameter int PIPE_MUL = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      i_init,
  input  logic [LANES*D_W-1:0]      i_a,
  input  logic [LANES*D_W-1:0]      i_b,
  output logic signed [D_W_ACC-1:0] o_dot,
  output logic                      o_init
);

  logic signed [D_W_ACC-1:0] w_dot;

  // Width rule guarantees the running sum never overflows D_W_ACC.
  always_comb begin
    w_dot = '0;
    for (int i = 0; i < LANES; i++) begin
      w_dot = w_dot + D_W_ACC'(signed'(i_a[lane_lo(i, D_W) +: D_W]) *
                               signed'(i_b[lane_lo(i, D_W) +: D_W]));
    end
  end

  if (PIPE_MUL != 0) begin : g_pipe
    logic signed [D_W_ACC-1:0] r_dot;
    logic                      r_init;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_dot  <= '0;
        r_init <= 1'b0;
      end else if (en) begin
        r_dot  <= w_dot;
        r_init <= i_init;
      end
    end

    assign o_dot  = r_dot;
    assign o_init = r_init;
  end else begin : g_comb
    assign o_dot  = w_dot;
    assign o_init = i_init;
  end

endmodule

// File: rtl/pe_vec.sv
// Vector systolic PE: LANES-wide signed dot product accumulated per step, results drained down the chain.
// Result 1+PIPE_MUL enabled cycles after init, drain 2, forward 1; en=0 freezes every register.
module pe_vec
  import pe_pkg::*;
#(
  parameter int D_W      = 8,
  parameter int D_W_ACC  = 32,
  parameter int LANES    = 4,
  parameter int PIPE_MUL = 1,
  parameter int SAT_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 init,
  input  logic [LANES*D_W-1:0] in_a,
  input  logic [LANES*D_W-1:0] in_b,
  input  logic [D_W_ACC-1:0]   in_data,
  input  logic                 in_valid,
  input  logic                 clr_ovf,
  output logic [LANES*D_W-1:0] out_a,
  output logic [LANES*D_W-1:0] out_b,
  output logic [D_W_ACC-1:0]   out_data,
  output logic                 out_valid,
  output logic                 ovf
);

  if (!width_ok(D_W, D_W_ACC, LANES)) begin : g_bad_width
    $error("pe_vec: D_W_ACC must cover 2*D_W+clog2(LANES) and fit in 64 bits");
  end

  logic signed [D_W_ACC-1:0] w_dot;
  logic                      w_init;
  logic signed [D_W_ACC:0]   w_sum;
  sat_res_t                  w_sat;

  logic [LANES*D_W-1:0]      r_out_a, r_out_b;
  logic [D_W_ACC-1:0]        r_in_data, r_out_data;
  logic                      r_in_valid, r_out_valid, r_ovf;
  logic signed [D_W_ACC-1:0] r_acc;

  pe_dot #(
    .D_W      (D_W),
    .D_W_ACC  (D_W_ACC),
    .LANES    (LANES),
    .PIPE_MUL (PIPE_MUL)
  ) u_dot (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .i_init (init),
    .i_a    (in_a),
    .i_b    (in_b),
    .o_dot  (w_dot),
    .o_init (w_init)
  );

  always_comb begin
    w_sum = {r_acc[D_W_ACC-1], r_acc} + {w_dot[D_W_ACC-1], w_dot};
    w_sat = sat_add((ACC_MAX_W + 1)'(w_sum), D_W_ACC, SAT_EN != 0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_in_data   <= '0;
      r_in_valid  <= 1'b0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (en) begin
      r_out_a    <= in_a;
      r_out_b    <= in_b;
      r_in_data  <= in_data;
      r_in_valid <= in_valid;
      // A local result takes the drain slot; a coincident upstream word is lost.
      if (w_init) begin
        r_out_data  <= r_acc;
        r_out_valid <= 1'b1;
        r_acc       <= w_dot;
      end else begin
        r_acc       <= D_W_ACC'(w_sat.val);
        r_out_data  <= r_in_data;
        r_out_valid <= r_in_valid;
      end
      if (!w_init && w_sat.ovf) r_ovf <= 1'b1;
      else if (clr_ovf)         r_ovf <= 1'b0;
    end
  end

  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pe_vec.sv
// Bench for pe_vec: pipelined and combinational 4-lane instances plus 16-bit single-lane sat/wrap instances.
module tb_pe_vec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, init, in_valid, clr_ovf;
  logic [31:0] a, b, in_data;
  logic [31:0] m_out_a, m_out_b, m_out_data, z_out_a, z_out_b, z_out_data;
  logic        m_out_valid, m_ovf, z_out_valid, z_ovf;
  logic [7:0]  s_a, s_b, s_out_a, s_out_b, w_out_a, w_out_b;
  logic        s_init, s_clr, s_out_valid, s_ovf, w_out_valid, w_ovf;
  logic [15:0] s_in_data, s_out_data, w_out_data;
  logic        s_in_valid;

  int          n_cmp = 0;
  int          n_err = 0;
  longint      t_acc = 0;
  logic [31:0] exp_q[$], obs_m[$], obs_z[$];

  pe_vec #(.PIPE_MUL(1)) u_m (
    .clk(clk), .rst_n(rst_n), .en(en), .init(init), .in_a(a), .in_b(b),
    .in_data(in_data), .in_valid(in_valid), .clr_ovf(clr_ovf),
    .out_a(m_out_a), .out_b(m_out_b), .out_data(m_out_data), .out_valid(m_out_valid), .ovf(m_ovf));

  pe_vec #(.PIPE_MUL(0)) u_z (
    .clk(clk), .rst_n(rst_n), .en(en), .init(init), .in_a(a), .in_b(b),
    .in_data(in_data), .in_valid(in_valid), .clr_ovf(clr_ovf),
    .out_a(z_out_a), .out_b(z_out_b), .out_data(z_out_data), .out_valid(z_out_valid), .ovf(z_ovf));

  pe_vec #(.D_W_ACC(16), .LANES(1), .SAT_EN(1)) u_s (
    .clk(clk), .rst_n(rst_n), .en(en), .init(s_init), .in_a(s_a), .in_b(s_b),
    .in_data(s_in_data), .in_valid(s_in_valid), .clr_ovf(s_clr),
    .out_a(s_out_a), .out_b(s_out_b), .out_data(s_out_data), .out_valid(s_out_valid), .ovf(s_ovf));

  pe_vec #(.D_W_ACC(16), .LANES(1), .SAT_EN(0)) u_w (
    .clk(clk), .rst_n(rst_n), .en(en), .init(s_init), .in_a(s_a), .in_b(s_b),
    .in_data(s_in_data), .in_valid(s_in_valid), .clr_ovf(s_clr),
    .out_a(w_out_a), .out_b(w_out_b), .out_data(w_out_data), .out_valid(w_out_valid), .ovf(w_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic longint dot_ref(input logic [31:0] x, input logic [31:0] y);
    longint           s = 0;
    logic signed [7:0] xa, yb;
    for (int i = 0; i < 4; i++) begin
      xa = x[i*8 +: 8];
      yb = y[i*8 +: 8];
      s += longint'(xa) * longint'(yb);
    end
    return s;
  endfunction

  // Drive one step, advance the reference accumulator, capture any emitted words.
  task automatic step(input logic [31:0] sa, input logic [31:0] sb, input logic si);
    a = sa; b = sb; init = si;
    if (en) begin
      if (si) begin
        exp_q.push_back(32'(t_acc));
        t_acc = dot_ref(sa, sb);
      end else begin
        t_acc += dot_ref(sa, sb);
      end
    end
    tick();
    if (en && m_out_valid) obs_m.push_back(m_out_data);
    if (en && z_out_valid) obs_z.push_back(z_out_data);
  endtask

  task automatic settle;
    step(0, 0, 0);
    step(0, 0, 0);
    exp_q.delete(); obs_m.delete(); obs_z.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; init = 1'b1; clr_ovf = 1'b0;
    a = 32'hA5A5_A5A5; b = 32'h5A5A_5A5A; in_data = 32'hFFFF; in_valid = 1'b1;
    s_a = 8'h7F; s_b = 8'h7F; s_init = 1'b0; s_clr = 1'b0; s_in_data = '0; s_in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({m_out_a, m_out_b} !== 64'h0) begin n_err++; $display("FAIL reset_fwd: got %h want 0", {m_out_a, m_out_b}); end
    n_cmp++; if ({m_out_valid, m_out_data} !== 33'h0) begin n_err++; $display("FAIL reset_drain: got %h want 0", {m_out_valid, m_out_data}); end
    n_cmp++; if ({m_ovf, z_ovf, s_ovf, w_ovf} !== 4'h0) begin n_err++; $display("FAIL reset_ovf: got %b want 0000", {m_ovf, z_ovf, s_ovf, w_ovf}); end
    n_cmp++; if ({z_out_valid, z_out_data, s_out_valid, s_out_a} !== 42'h0) begin n_err++; $display("FAIL reset_other: got %h want 0", {z_out_valid, z_out_data, s_out_valid, s_out_a}); end
    rst_n = 1'b1; init = 1'b0; a = '0; b = '0; in_data = '0; in_valid = 1'b0; s_a = '0; s_b = '0;
    t_acc = 0;
  endtask

  task automatic test_dot;
    logic [31:0] va = 32'h0403_0201, vb = 32'h0807_0605, e;
    settle();
    step(va, vb, 0);
    n_cmp++; if ({m_out_a, m_out_b} !== {va, vb}) begin n_err++; $display("FAIL fwd: got %h want %h", {m_out_a, m_out_b}, {va, vb}); end
    step(va, vb, 0);
    step(va, vb, 0);
    step(0, 0, 1);
    e = exp_q.pop_front();
    n_cmp++; if ({z_out_valid, z_out_data} !== {1'b1, e}) begin n_err++; $display("FAIL dot_nopipe: got %h want %h", {z_out_valid, z_out_data}, {1'b1, e}); end
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL dot_pipe_early: got %b want 0", m_out_valid); end
    step(0, 0, 0);
    n_cmp++; if ({m_out_valid, m_out_data} !== {1'b1, e}) begin n_err++; $display("FAIL dot_pipe: got %h want %h", {m_out_valid, m_out_data}, {1'b1, e}); end
    n_cmp++; if (z_out_valid !== 1'b0) begin n_err++; $display("FAIL dot_nopipe_drop: got %b want 0", z_out_valid); end
  endtask

  task automatic test_drain;
    settle();
    in_data = 32'h1234; in_valid = 1'b1;
    step(0, 0, 0);
    in_data = '0; in_valid = 1'b0;
    n_cmp++; if ({m_out_valid, z_out_valid} !== 2'b00) begin n_err++; $display("FAIL drain_early: got %b want 00", {m_out_valid, z_out_valid}); end
    step(0, 0, 0);
    n_cmp++; if ({m_out_valid, m_out_data} !== {1'b1, 32'h1234}) begin n_err++; $display("FAIL drain_m: got %h want 1_00001234", {m_out_valid, m_out_data}); end
    n_cmp++; if ({z_out_valid, z_out_data} !== {1'b1, 32'h1234}) begin n_err++; $display("FAIL drain_z: got %h want 1_00001234", {z_out_valid, z_out_data}); end
    step(0, 0, 0);
    n_cmp++; if ({m_out_valid, z_out_valid} !== 2'b00) begin n_err++; $display("FAIL drain_late: got %b want 00", {m_out_valid, z_out_valid}); end
  endtask

  task automatic drain_compare(input string tag);
    logic [31:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_m.size() == 0) begin n_err++; $display("FAIL %s_m: got nothing want %h", tag, e); end
      else begin o = obs_m.pop_front(); if (o !== e) begin n_err++; $display("FAIL %s_m: got %h want %h", tag, o, e); end end
      n_cmp++;
      if (obs_z.size() == 0) begin n_err++; $display("FAIL %s_z: got nothing want %h", tag, e); end
      else begin o = obs_z.pop_front(); if (o !== e) begin n_err++; $display("FAIL %s_z: got %h want %h", tag, o, e); end end
    end
    n_cmp++;
    if (obs_m.size() + obs_z.size() != 0) begin
      n_err++; $display("FAIL %s_extra: got %0d surplus words want 0", tag, obs_m.size() + obs_z.size());
    end
  endtask

  task automatic test_patterns;
    settle();
    for (int t = 0; t < 4; t++) begin
      step($urandom(), $urandom(), 1);
      repeat ($urandom_range(1, 4)) step($urandom(), $urandom(), 0);
    end
    repeat (3) step($urandom(), $urandom(), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    drain_compare("patterns");
  endtask

  task automatic test_stall;
    logic [31:0] xa = $urandom(), xb = $urandom(), pv;
    settle();
    pv = 32'(t_acc);
    step(xa, xb, 1);
    en = 1'b0; clr_ovf = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = $urandom(); b = $urandom(); init = k[0]; in_valid = 1'b1; in_data = $urandom();
      tick();
      n_cmp++; if (m_out_a !== xa) begin n_err++; $display("FAIL stall_fwd: got %h want %h", m_out_a, xa); end
      n_cmp++; if ({z_out_valid, z_out_data} !== {1'b1, pv}) begin n_err++; $display("FAIL stall_z: got %h want %h", {z_out_valid, z_out_data}, {1'b1, pv}); end
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_m: got %b want 0", m_out_valid); end
    end
    en = 1'b1; clr_ovf = 1'b0; in_valid = 1'b0; in_data = '0;
    step($urandom(), $urandom(), 0);
    step($urandom(), $urandom(), 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    drain_compare("stall");
  endtask

  task automatic test_collision;
    logic [31:0] e;
    settle();
    step($urandom(), $urandom(), 0);
    e = 32'(t_acc);
    in_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    step(0, 0, 1);
    in_data = '0; in_valid = 1'b0;
    n_cmp++; if ({z_out_valid, z_out_data} !== {1'b1, e}) begin n_err++; $display("FAIL coll_z_local: got %h want %h", {z_out_valid, z_out_data}, {1'b1, e}); end
    step(0, 0, 0);
    n_cmp++; if ({m_out_valid, m_out_data} !== {1'b1, e}) begin n_err++; $display("FAIL coll_m_local: got %h want %h", {m_out_valid, m_out_data}, {1'b1, e}); end
    n_cmp++; if ({z_out_valid, z_out_data} !== {1'b1, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL coll_z_drain: got %h want 1_deadbeef", {z_out_valid, z_out_data}); end
    step(0, 0, 0);
    n_cmp++; if ({m_out_valid, z_out_valid} !== 2'b00) begin n_err++; $display("FAIL coll_dropped: got %b want 00", {m_out_valid, z_out_valid}); end
  endtask

  task automatic test_sat;
    logic [7:0]        ta [8] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00};
    bit                ti [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit                tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit                tov[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    longint            acc_s = 0, acc_w = 0, p, t;
    logic signed [7:0] v;
    logic [15:0]       wv, e, qs[$], qw[$];
    for (int k = 0; k < 8; k++) begin
      v = ta[k];
      p = longint'(v) * longint'(v);
      if (ti[k]) begin
        qs.push_back(16'(acc_s)); qw.push_back(16'(acc_w));
        acc_s = p; acc_w = p;
      end else begin
        t = acc_s + p;
        acc_s = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
        wv = 16'(acc_w + p);
        acc_w = longint'($signed(wv));
      end
      s_a = ta[k]; s_b = ta[k]; s_init = ti[k]; s_clr = tc[k];
      tick();
      n_cmp++; if (s_ovf !== tov[k]) begin n_err++; $display("FAIL sat_ovf[%0d]: got %b want %b", k, s_ovf, tov[k]); end
      n_cmp++; if (w_ovf !== tov[k]) begin n_err++; $display("FAIL wrap_ovf[%0d]: got %b want %b", k, w_ovf, tov[k]); end
      if (s_out_valid) begin
        n_cmp++;
        if (qs.size() == 0) begin n_err++; $display("FAIL sat_word[%0d]: got %h want none", k, s_out_data); end
        else begin e = qs.pop_front(); if (s_out_data !== e) begin n_err++; $display("FAIL sat_word[%0d]: got %h want %h", k, s_out_data, e); end end
      end
      if (w_out_valid) begin
        n_cmp++;
        if (qw.size() == 0) begin n_err++; $display("FAIL wrap_word[%0d]: got %h want none", k, w_out_data); end
        else begin e = qw.pop_front(); if (w_out_data !== e) begin n_err++; $display("FAIL wrap_word[%0d]: got %h want %h", k, w_out_data, e); end end
      end
    end
    s_a = '0; s_b = '0; s_init = 1'b0; s_clr = 1'b0;
    n_cmp++;
    if (qs.size() + qw.size() != 0) begin n_err++; $display("FAIL sat_missing: got %0d unseen words want 0", qs.size() + qw.size()); end
  endtask

  task automatic test_reset_mid;
    settle();
    step(0, 0, 1);
    step(32'h0000_0007, 32'h0000_000B, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b0; a = 32'h1122_3344; b = 32'h5566_7788; init = 1'b1; in_valid = 1'b1; in_data = 32'd5;
    tick();
    n_cmp++; if ({m_out_a, m_out_b} !== 64'h0) begin n_err++; $display("FAIL rstmid_fwd: got %h want 0", {m_out_a, m_out_b}); end
    n_cmp++; if ({m_out_valid, m_out_data, m_ovf} !== 34'h0) begin n_err++; $display("FAIL rstmid_m: got %h want 0", {m_out_valid, m_out_data, m_ovf}); end
    n_cmp++; if ({z_out_valid, z_out_data, z_out_a} !== 65'h0) begin n_err++; $display("FAIL rstmid_z: got %h want 0", {z_out_valid, z_out_data, z_out_a}); end
    rst_n = 1'b1; init = 1'b0; in_valid = 1'b0; in_data = '0;
    t_acc = 0;
    exp_q.delete(); obs_m.delete(); obs_z.delete();
    step(32'h0000_0001, 32'h0000_0005, 0);
    step(32'h0000_0001, 32'h0000_0005, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    drain_compare("rstmid");
  endtask

  initial begin
    test_reset();
    test_dot();
    test_drain();
    test_patterns();
    test_stall();
    test_collision();
    test_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
